// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: mode codes, arbiter
// state encoding, PIO register map and reset values.
package led_seq_pkg;

    localparam logic [1:0] MODE_ROTL  = 2'd0;
    localparam logic [1:0] MODE_BLINK = 2'd1;
    localparam logic [1:0] MODE_COUNT = 2'd2;
    localparam logic [1:0] MODE_HOLD  = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } arb_state_t;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
    localparam logic [7:0] RESET_PATTERN = 8'h01;
    localparam logic [7:0] OVERRUN_MAX   = 8'hFF;

endpackage

// File: rtl/led_seq_prescaler.sv
// Tick prescaler: one-cycle tick every tick_div+1 cycles while enabled,
// counter parked at zero while disabled.
module led_seq_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] tick_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // >= rather than == so a tick_div lowered below the running count
    // restarts the period instead of wrapping through the full range.
    always_comb begin
        tick  = enable && (cnt_q >= tick_div);
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern engine plus a two-requester round-robin arbiter that
// drives single-cycle writes into the PIO data register.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  tick_div,
    input  logic              host_req,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_gnt,
    output logic [1:0]        pio_address,
    output logic              pio_chipselect,
    output logic              pio_write_n,
    output logic [DATA_W-1:0] pio_writedata,
    output logic [DATA_W-1:0] pattern,
    output logic [7:0]        overrun_cnt
);

    logic tick;

    led_seq_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .tick_div (tick_div),
        .tick     (tick)
    );

    logic [DATA_W-1:0] pattern_q;
    logic [DATA_W-1:0] pattern_d;
    logic              pat_pend_q;
    logic              pat_pend_d;
    logic [7:0]        overrun_q;
    logic [7:0]        overrun_d;

    arb_state_t        state_q;
    logic              last_host_q;
    logic [DATA_W-1:0] wdata_q;
    logic              cs_q;
    logic              write_n_q;
    logic              gnt_q;

    logic advance;
    logic grant_host;
    logic grant_engine;

    // Round-robin: on a tie the requester that did not win last time goes.
    always_comb begin
        advance      = tick && (mode != MODE_HOLD);
        grant_host   = (state_q == ST_IDLE) && host_req &&
                       (!pat_pend_q || !last_host_q);
        grant_engine = (state_q == ST_IDLE) && pat_pend_q &&
                       (!host_req || last_host_q);
    end

    always_comb begin
        pattern_d = pattern_q;
        if (advance) begin
            case (mode)
                MODE_ROTL:  pattern_d = {pattern_q[DATA_W-2:0], pattern_q[DATA_W-1]};
                MODE_BLINK: pattern_d = ~pattern_q;
                MODE_COUNT: pattern_d = pattern_q + DATA_W'(1);
                default:    pattern_d = pattern_q;
            endcase
        end
    end

    // A tick that lands while an unserved pattern write is outstanding is
    // folded into it; a tick coinciding with the engine grant re-arms it.
    always_comb begin
        pat_pend_d = pat_pend_q;
        if (grant_engine) begin
            pat_pend_d = 1'b0;
        end
        if (advance) begin
            pat_pend_d = 1'b1;
        end

        overrun_d = overrun_q;
        if (advance && pat_pend_q && !grant_engine && (overrun_q != OVERRUN_MAX)) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q  <= DATA_W'(RESET_PATTERN);
            pat_pend_q <= 1'b0;
            overrun_q  <= 8'd0;
        end else begin
            pattern_q  <= pattern_d;
            pat_pend_q <= pat_pend_d;
            overrun_q  <= overrun_d;
        end
    end

    // Arbiter FSM with registered PIO strobes; WRITE always lasts one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            last_host_q <= 1'b0;
            wdata_q     <= '0;
            cs_q        <= 1'b0;
            write_n_q   <= 1'b1;
            gnt_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_host || grant_engine) begin
                        state_q     <= ST_WRITE;
                        last_host_q <= grant_host;
                        wdata_q     <= grant_host ? host_data : pattern_q;
                        cs_q        <= 1'b1;
                        write_n_q   <= 1'b0;
                        gnt_q       <= grant_host;
                    end else begin
                        cs_q      <= 1'b0;
                        write_n_q <= 1'b1;
                        gnt_q     <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    state_q   <= ST_IDLE;
                    cs_q      <= 1'b0;
                    write_n_q <= 1'b1;
                    gnt_q     <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    cs_q      <= 1'b0;
                    write_n_q <= 1'b1;
                    gnt_q     <= 1'b0;
                end
            endcase
        end
    end

    assign host_gnt       = gnt_q;
    assign pio_address    = PIO_DATA_ADDR;
    assign pio_chipselect = cs_q;
    assign pio_write_n    = write_n_q;
    assign pio_writedata  = wdata_q;
    assign pattern        = pattern_q;
    assign overrun_cnt    = overrun_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl: a negedge monitor logs every PIO write,
// and one task per scenario compares against hand-derived values.
module tb_led_seq_ctrl;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [1:0]  mode;
    logic [15:0] tick_div;
    logic        host_req;
    logic [7:0]  host_data;
    logic        host_gnt;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [7:0]  pio_writedata;
    logic [7:0]  pattern;
    logic [7:0]  overrun_cnt;

    int checks;
    int errors;

    led_seq_ctrl #(
        .DATA_W (8),
        .DIV_W  (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .mode           (mode),
        .tick_div       (tick_div),
        .host_req       (host_req),
        .host_data      (host_data),
        .host_gnt       (host_gnt),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pattern        (pattern),
        .overrun_cnt    (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log filled mid-cycle
    bit         mon_on;
    int         cyc;
    logic [7:0] wr_data [$];
    bit         wr_host [$];
    int         wr_cyc  [$];
    int         cs_run;
    int         max_cs_run;
    int         strobe_bad;

    always @(negedge clk) begin
        cyc++;
        if (mon_on) begin
            if (pio_chipselect === 1'b1) begin
                wr_data.push_back(pio_writedata);
                wr_host.push_back(host_gnt);
                wr_cyc.push_back(cyc);
                cs_run++;
                if (cs_run > max_cs_run) max_cs_run = cs_run;
            end else begin
                cs_run = 0;
            end
            if ((pio_chipselect !== ~pio_write_n) || (pio_address !== 2'd0) ||
                (host_gnt === 1'b1 && pio_chipselect !== 1'b1))
                strobe_bad++;
        end
    end

    task automatic clear_log();
        wr_data.delete();
        wr_host.delete();
        wr_cyc.delete();
        max_cs_run = 0;
    endtask

    // Leaves the bench at the negedge where reset was released (cycle 0).
    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        enable    = 1'b0;
        mode      = 2'd0;
        tick_div  = 16'd0;
        host_req  = 1'b0;
        host_data = 8'h00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        clear_log();
    endtask

    task automatic test_reset();
        enable = 1'b0; mode = 2'd0; tick_div = 16'd0; host_req = 1'b0; host_data = 8'h00;
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (pio_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs actual=%b required=0", pio_chipselect); end
        checks++; if (pio_write_n !== 1'b1) begin errors++; $display("FAIL reset_write_n actual=%b required=1", pio_write_n); end
        checks++; if (pio_address !== 2'd0) begin errors++; $display("FAIL reset_addr actual=%0d required=0", pio_address); end
        checks++; if (pio_writedata !== 8'h00) begin errors++; $display("FAIL reset_wdata actual=%h required=00", pio_writedata); end
        checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt actual=%b required=0", host_gnt); end
        checks++; if (pattern !== 8'h01) begin errors++; $display("FAIL reset_pattern actual=%h required=01", pattern); end
        checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL reset_overrun actual=%0d required=0", overrun_cnt); end
        reset_n = 1'b1;
        mon_on  = 1'b1;
        clear_log();
        repeat (3) @(negedge clk);
        checks++; if (pattern !== 8'h01 || wr_data.size() != 0) begin
            errors++; $display("FAIL reset_idle pattern=%h writes=%0d required pattern=01 writes=0", pattern, wr_data.size());
        end
        $display("test_reset done");
    endtask

    task automatic test_rotate();
        logic [7:0] exp_d [4] = '{8'h02, 8'h04, 8'h08, 8'h10};
        do_reset();
        enable = 1'b1; mode = 2'd0; tick_div = 16'd3;
        repeat (20) @(negedge clk);
        enable = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (wr_data.size() < 4) begin
            errors++; $display("FAIL rot_count actual=%0d required>=4", wr_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_data[i] !== exp_d[i] || wr_host[i] !== 1'b0) begin
                    errors++; $display("FAIL rot_data[%0d] actual=%h host=%b required=%h host=0", i, wr_data[i], wr_host[i], exp_d[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (wr_cyc[i] - wr_cyc[i-1] != 4) begin
                        errors++; $display("FAIL rot_period[%0d] actual=%0d required=4", i, wr_cyc[i] - wr_cyc[i-1]);
                    end
                end
            end
        end
        checks++; if (max_cs_run != 1) begin errors++; $display("FAIL rot_cs_width actual=%0d required=1", max_cs_run); end
        $display("test_rotate writes=%0d", wr_data.size());
    endtask

    task automatic test_count_wrap();
        logic [7:0] exp_d [5] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
        do_reset();
        enable = 1'b1; mode = 2'd1; tick_div = 16'd0;
        @(negedge clk);
        mode = 2'd2; tick_div = 16'd1;
        repeat (8) @(negedge clk);
        enable = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (wr_data.size() != 5) begin
            errors++; $display("FAIL wrap_count actual=%0d required=5", wr_data.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wr_data[i] !== exp_d[i]) begin
                    errors++; $display("FAIL wrap_data[%0d] actual=%h required=%h", i, wr_data[i], exp_d[i]);
                end
            end
        end
        checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL wrap_overrun actual=%0d required=0", overrun_cnt); end
        checks++; if (pattern !== 8'h02) begin errors++; $display("FAIL wrap_pattern actual=%h required=02", pattern); end
        $display("test_count_wrap writes=%0d", wr_data.size());
    endtask

    task automatic test_coalesce();
        logic [7:0] exp_d [4] = '{8'h02, 8'h04, 8'h06, 8'h07};
        do_reset();
        enable = 1'b1; mode = 2'd2; tick_div = 16'd0;
        repeat (6) @(negedge clk);
        enable = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (wr_data.size() != 4) begin
            errors++; $display("FAIL coal_count actual=%0d required=4", wr_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_data[i] !== exp_d[i]) begin
                    errors++; $display("FAIL coal_data[%0d] actual=%h required=%h", i, wr_data[i], exp_d[i]);
                end
            end
        end
        checks++; if (overrun_cnt !== 8'd2) begin errors++; $display("FAIL coal_overrun actual=%0d required=2", overrun_cnt); end
        checks++; if (pattern !== 8'h07) begin errors++; $display("FAIL coal_pattern actual=%h required=07", pattern); end
        $display("test_coalesce overrun=%0d", overrun_cnt);
    endtask

    task automatic test_host_first();
        do_reset();
        enable = 1'b1; mode = 2'd0; tick_div = 16'd0;
        @(negedge clk);
        enable = 1'b0; host_req = 1'b1; host_data = 8'hA5;
        checks++; if (pio_chipselect !== 1'b0) begin errors++; $display("FAIL hf_idle_cs actual=%b required=0", pio_chipselect); end
        @(negedge clk);
        checks++; if (pio_chipselect !== 1'b1 || pio_write_n !== 1'b0) begin
            errors++; $display("FAIL hf_host_strobe cs=%b wn=%b required cs=1 wn=0", pio_chipselect, pio_write_n);
        end
        checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL hf_host_gnt actual=%b required=1", host_gnt); end
        checks++; if (pio_writedata !== 8'hA5) begin errors++; $display("FAIL hf_host_data actual=%h required=a5", pio_writedata); end
        host_req = 1'b0;
        @(negedge clk);
        checks++; if (pio_chipselect !== 1'b0 || host_gnt !== 1'b0) begin
            errors++; $display("FAIL hf_gap cs=%b gnt=%b required cs=0 gnt=0", pio_chipselect, host_gnt);
        end
        @(negedge clk);
        checks++; if (pio_chipselect !== 1'b1 || host_gnt !== 1'b0 || pio_writedata !== 8'h02) begin
            errors++; $display("FAIL hf_engine cs=%b gnt=%b data=%h required cs=1 gnt=0 data=02", pio_chipselect, host_gnt, pio_writedata);
        end
        repeat (4) @(negedge clk);
        checks++; if (wr_data.size() != 2) begin errors++; $display("FAIL hf_count actual=%0d required=2", wr_data.size()); end
        $display("test_host_first writes=%0d", wr_data.size());
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [6] = '{8'h3C, 8'h04, 8'h3C, 8'h40, 8'h3C, 8'h04};
        bit         exp_h [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        enable = 1'b1; mode = 2'd0; tick_div = 16'd0; host_req = 1'b1; host_data = 8'h3C;
        repeat (12) @(negedge clk);
        host_req = 1'b0; enable = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (wr_data.size() < 6) begin
            errors++; $display("FAIL rr_count actual=%0d required>=6", wr_data.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wr_data[i] !== exp_d[i] || wr_host[i] !== exp_h[i]) begin
                    errors++; $display("FAIL rr_write[%0d] data=%h host=%b required data=%h host=%b", i, wr_data[i], wr_host[i], exp_d[i], exp_h[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (wr_cyc[i] - wr_cyc[i-1] != 2) begin
                        errors++; $display("FAIL rr_spacing[%0d] actual=%0d required=2", i, wr_cyc[i] - wr_cyc[i-1]);
                    end
                end
            end
        end
        $display("test_round_robin writes=%0d", wr_data.size());
    endtask

    task automatic test_reset_mid_write();
        bit found = 1'b0;
        do_reset();
        enable = 1'b1; mode = 2'd0; tick_div = 16'd0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (pio_chipselect === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL mid_wait actual=no_write required=write_within_20");
        end else begin
            reset_n = 1'b0;
            #1;
            checks++; if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1) begin
                errors++; $display("FAIL mid_abort cs=%b wn=%b required cs=0 wn=1", pio_chipselect, pio_write_n);
            end
        end
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        clear_log();
        @(negedge clk);
        checks++; if (pattern !== 8'h01) begin errors++; $display("FAIL mid_pattern actual=%h required=01", pattern); end
        checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL mid_overrun actual=%0d required=0", overrun_cnt); end
        checks++; if (wr_data.size() != 0) begin errors++; $display("FAIL mid_no_strobe actual=%0d required=0", wr_data.size()); end
        $display("test_reset_mid_write done");
    endtask

    task automatic test_hold_saturate();
        do_reset();
        mode = 2'd3; tick_div = 16'd0;
        repeat (100) @(negedge clk);
        checks++; if (wr_data.size() != 0 || pattern !== 8'h01) begin
            errors++; $display("FAIL disabled writes=%0d pattern=%h required writes=0 pattern=01", wr_data.size(), pattern);
        end
        enable = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (wr_data.size() != 0 || pattern !== 8'h01) begin
            errors++; $display("FAIL hold_mode writes=%0d pattern=%h required writes=0 pattern=01", wr_data.size(), pattern);
        end
        do_reset();
        enable = 1'b1; mode = 2'd0; tick_div = 16'd0; host_req = 1'b1; host_data = 8'h81;
        repeat (8) @(negedge clk);
        checks++; if (overrun_cnt !== 8'd5) begin errors++; $display("FAIL sat_early actual=%0d required=5", overrun_cnt); end
        repeat (492) @(negedge clk);
        checks++; if (overrun_cnt !== 8'd255) begin errors++; $display("FAIL sat_value actual=%0d required=255", overrun_cnt); end
        repeat (50) @(negedge clk);
        checks++; if (overrun_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold actual=%0d required=255", overrun_cnt); end
        host_req = 1'b0; enable = 1'b0;
        repeat (6) @(negedge clk);
        $display("test_hold_saturate overrun=%0d", overrun_cnt);
    endtask

    task automatic test_strobes();
        checks++; if (strobe_bad != 0) begin errors++; $display("FAIL strobe_consistency actual=%0d required=0", strobe_bad); end
        $display("test_strobes bad=%0d", strobe_bad);
    endtask

    initial begin
        checks = 0; errors = 0; mon_on = 1'b0; cyc = 0; cs_run = 0; max_cs_run = 0; strobe_bad = 0;
        test_reset();
        test_rotate();
        test_count_wrap();
        test_coalesce();
        test_host_first();
        test_round_robin();
        test_reset_mid_write();
        test_hold_saturate();
        test_strobes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
